// File: rtl/search_window_buf.sv
// Row-shifting WIN_H x WIN_W search window for the block-matching SAD array.
// Rows enter at the bottom (row WIN_H-1) and age towards row 0.

module swb_row #(
  parameter int ROW_W = 152
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic [ROW_W-1:0] d,
  output logic [ROW_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)        q <= '0;
    else if (shift) q <= d;
  end
endmodule

module search_window_buf #(
  parameter int PIX_W = 8,
  parameter int WIN_W = 19,
  parameter int WIN_H = 19,
  parameter int CNT_W = 16,
  localparam int FW    = $clog2(WIN_H + 1),
  localparam int ROW_W = WIN_W * PIX_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ROW_W-1:0]               in_row,
  input  logic                           advance,
  input  logic                           flush,
  output logic                           win_valid,
  output logic                           win_new,
  output logic [WIN_H*ROW_W-1:0]         win_data,
  output logic [FW-1:0]                  fill_cnt,
  output logic [CNT_W-1:0]               win_count
);

  typedef enum logic {FILL, FULL} state_t;

  state_t                      state_q, state_d;
  logic [FW-1:0]               fill_d;
  logic                        valid_d, new_d;
  logic                        accept;
  logic [WIN_H-1:0][ROW_W-1:0] rows;

  assign in_ready = !flush && ((state_q == FILL) || advance);
  assign accept   = in_valid && in_ready;
  assign win_data = rows;

  // Each row loads from the row below it; the bottom row takes the new input.
  genvar r;
  generate
    for (r = 0; r < WIN_H; r++) begin : g_row
      if (r == WIN_H - 1) begin : g_top
        swb_row #(.ROW_W(ROW_W)) u_row (
          .clk(clk), .rst(rst), .shift(accept), .d(in_row), .q(rows[r])
        );
      end else begin : g_mid
        swb_row #(.ROW_W(ROW_W)) u_row (
          .clk(clk), .rst(rst), .shift(accept), .d(rows[r+1]), .q(rows[r])
        );
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    fill_d  = fill_cnt;
    valid_d = win_valid;
    new_d   = 1'b0;
    if (flush) begin
      state_d = FILL;
      fill_d  = '0;
      valid_d = 1'b0;
    end else if (accept) begin
      if (state_q == FILL) begin
        fill_d = fill_cnt + 1'b1;
        if (fill_cnt == FW'(WIN_H - 1)) begin
          state_d = FULL;
          valid_d = 1'b1;
          new_d   = 1'b1;
        end
      end else begin
        new_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      fill_cnt  <= '0;
      win_valid <= 1'b0;
      win_new   <= 1'b0;
      win_count <= '0;
    end else begin
      state_q   <= state_d;
      fill_cnt  <= fill_d;
      win_valid <= valid_d;
      win_new   <= new_d;
      if (new_d) win_count <= win_count + 1'b1;
    end
  end

endmodule
